// File: rtl/dsam_pkg.sv
// dsam_pkg: shared widths and word type for the differential encoder/decoder pair
// Provides DSAM_DATA_WIDTH and DSAM_CHANNELS as defaults, and dsam_word_t as the bus word.
package dsam_pkg;
    localparam int DSAM_DATA_WIDTH = 16;
    localparam int DSAM_CHANNELS   = 4;
    typedef logic [DSAM_DATA_WIDTH-1:0] dsam_word_t;
endpackage

// File: rtl/dsam_delay_line.sv
// dsam_delay_line: DEPTH-deep shift register with async active-low clear, exposing its oldest tap
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low clear of every stage
//   d_i      - word shifted into stage 0 on every edge
//   oldest_o - stage DEPTH-1, the word written DEPTH edges ago
module dsam_delay_line
    import dsam_pkg::*;
#(
    parameter int WIDTH = DSAM_DATA_WIDTH,
    parameter int DEPTH = DSAM_CHANNELS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] oldest_o
);
    logic [WIDTH-1:0] hist_q [DEPTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) hist_q[k] <= '0;
        end else begin
            hist_q[0] <= d_i;
            for (int k = 1; k < DEPTH; k++) hist_q[k] <= hist_q[k-1];
        end
    end
    assign oldest_o = hist_q[DEPTH-1];
endmodule

// File: rtl/dsam_encoder.sv
// dsam_encoder: per-channel differential encoder for CHANNELS round-robin interleaved words
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset; clears history and output
//   in    - raw sample, one per clock
//   out   - registered in minus the sample CHANNELS cycles earlier, modulo 2^DATA_WIDTH
module dsam_encoder
    import dsam_pkg::*;
#(
    parameter int DATA_WIDTH = DSAM_DATA_WIDTH,
    parameter int CHANNELS   = DSAM_CHANNELS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0] out
);
    logic [DATA_WIDTH-1:0] oldest;
    logic [DATA_WIDTH-1:0] out_d;
    logic [DATA_WIDTH-1:0] out_q;
    dsam_delay_line #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(CHANNELS)
    ) u_hist (
        .clk     (clk),
        .rst_n   (reset),
        .d_i     (in),
        .oldest_o(oldest)
    );
    // Unsigned wrap is intended: the decoder's modular accumulation undoes it exactly.
    assign out_d = in - oldest;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) out_q <= '0;
        else        out_q <= out_d;
    end
    assign out = out_q;
endmodule

// File: tb/tb_dsam_encoder.sv
// tb_dsam_encoder: directed checks of dsam_encoder (CHANNELS=4 and CHANNELS=1) against a sample-history model
module tb_dsam_encoder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] din = 16'h0;
    logic [15:0] out4;
    logic [15:0] out1;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] samples [$];
    logic [15:0] e4 = 16'h0;
    logic [15:0] e1 = 16'h0;
    int          n;

    always #5 clk = ~clk;

    dsam_encoder #(.DATA_WIDTH(16), .CHANNELS(4)) u4 (
        .clk  (clk),
        .reset(reset),
        .in   (din),
        .out  (out4)
    );
    dsam_encoder #(.DATA_WIDTH(16), .CHANNELS(1)) u1 (
        .clk  (clk),
        .reset(reset),
        .in   (din),
        .out  (out1)
    );

    // Model: every sample since the last reset is kept; a channel's previous
    // sample is the one CHANNELS positions back, or zero if none exists yet.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            samples.delete();
            e4 = 16'h0;
            e1 = 16'h0;
        end else begin
            n = samples.size();
            e4 = din - ((n >= 4) ? samples[n-4] : 16'h0);
            e1 = din - ((n >= 1) ? samples[n-1] : 16'h0);
            samples.push_back(din);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_ch4", out4, e4);
        chk("model_ch1", out1, e1);
    end

    // Drive a sample, let one edge capture it; returns at posedge+2 with out updated.
    task automatic put(input logic [15:0] v);
        din = v;
        @(posedge clk);
        #2;
    endtask

    // Pulse reset between edges and confirm the output clears without a clock.
    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        chk("async_clear_ch4", out4, 16'h0);
        chk("async_clear_ch1", out1, 16'h0);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] ramp_exp [8];
        ramp_exp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4};
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            put(16'(16'hA5A5 ^ i));
            chk("held_reset_ch4", out4, 16'h0);
            chk("held_reset_ch1", out1, 16'h0);
        end
        reset = 1'b1;
        put(16'h0005);
        chk("release_ch4", out4, 16'h0005);
        chk("release_ch1", out1, 16'h0005);

        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            put(16'(i + 1));
            chk("ramp_ch4", out4, ramp_exp[i]);
            chk("ramp_ch1", out1, 16'd1);
        end

        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            put(16'h1234);
            chk("const_ch4", out4, (i < 4) ? 16'h1234 : 16'h0000);
            chk("const_ch1", out1, (i < 1) ? 16'h1234 : 16'h0000);
        end

        pulse_reset();
        put(16'h0001);
        put(16'h0000);
        chk("wrap_ch1", out1, 16'hFFFF);
        put(16'h0000);
        put(16'h0000);
        put(16'h0000);
        chk("wrap_0_minus_1", out4, 16'hFFFF);
        put(16'hFFFF);
        chk("wrap_ffff_minus_0", out4, 16'hFFFF);

        pulse_reset();
        for (int i = 0; i < 6; i++) put(16'(i + 1));
        chk("pre_reset_ch4", out4, 16'd4);
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            put(16'(10 + i));
            chk("restart_ch4", out4, 16'(10 + i));
        end
        put(16'd14);
        chk("restart_diff_ch4", out4, 16'd4);

        pulse_reset();
        put(16'd3);
        chk("ch1_first", out1, 16'd3);
        put(16'd5);
        chk("ch1_second", out1, 16'd2);
        put(16'd4);
        chk("ch1_third", out1, 16'hFFFF);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dsam_encoder.md
Name: dsam_encoder

Overview:
- Streaming differential encoder for CHANNELS time-interleaved data channels sharing one bus. One word arrives per clock, and consecutive words belong to consecutive channels in round-robin order.
- Each output word is the difference between the current input and the previous input of the same channel, which is the input CHANNELS cycles earlier.
- Sits on the transmit side of the data path ahead of serialisation. A matching decoder inverts it by running accumulation per channel.

Parameters:
- DATA_WIDTH, 16, width of the input and output words in bits.
- CHANNELS, 4, number of interleaved channels, which is also the history depth. Legal values are 1 or greater.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  asynchronous, active-low reset. When 0 it clears all state immediately.
- in  input  DATA_WIDTH  raw sample, one per clock, with no handshake.
- out  output  DATA_WIDTH  registered encoded word.

Behaviour:
- History is a delay line of CHANNELS words, hist[0..CHANNELS-1], where hist[CHANNELS-1] is the oldest.
- While reset=0, asynchronously:
  - all hist entries are 0;
  - out is 0.
- On each rising clk edge with reset=1:
  - out <= in - hist[CHANNELS-1], modulo 2^DATA_WIDTH, unsigned wrap with no saturation;
  - hist shifts by one: hist[0] <= in and hist[k] <= hist[k-1].
- Latency is 1 cycle. out reflects the in value sampled at the preceding edge and is stable for the whole following cycle.
- The first CHANNELS samples after reset are encoded against 0, so out equals the raw input for those samples.
- Wrap-around:
  - in=0x0000 with history 0x0001 gives out=0xFFFF;
  - in=0xFFFF with history 0x0000 gives out=0xFFFF.
- CHANNELS=1 degenerates to a plain first-difference encoder.
- No valid or enable signal: every clock is a sample, and the bus is driven continuously.
- Reset asserted mid-stream:
  - out and history clear at once, without waiting for clk;
  - after release, encoding restarts against zero history.
  - Release is assumed synchronous to clk by the surrounding reset synchroniser.
- There is no X-propagation requirement beyond reset. All registers have defined reset values.

Decomposition:
- Shared package dsam_pkg holds:
  - default constants DSAM_DATA_WIDTH=16 and DSAM_CHANNELS=4;
  - a word typedef of DSAM_DATA_WIDTH bits, used by the encoder and the companion decoder.
- One sub-module is natural: dsam_delay_line, a parameterised CHANNELS-deep shift register with asynchronous active-low clear that exposes its oldest tap.
- The subtractor and the output register stay in dsam_encoder.

Test Plan:
- Reset behaviour: hold reset=0 and toggle in. Then out=0x0000 throughout. After release with in=0x0005, out=0x0005 on the next edge.
- Ramp, default parameters: after reset, in=1,2,3,4,5,6,7,8 on successive edges. Then out on the following edges is 1,2,3,4,4,4,4,4.
- Constant input: in=0x1234 held for 8 cycles after reset. Then out is 0x1234 for 4 cycles, then 0x0000.
- Wrap-around: channel history 0x0001, then in=0x0000 on that channel's slot. Then out=0xFFFF.
- Mid-stream reset: during the ramp, pulse reset=0 between edges. Then out drops to 0 immediately. The next four samples are output unchanged.
- Parameter sweep: CHANNELS=1 with in=3,5,4. Then out=3,2,0xFFFF.
